// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one single-port synchronous SRAM between the inst and data ports
// Build option: define ARB_RR_EN for alternating contention grants instead of data priority with a starvation guard.
module sram_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic [DW-1:0]   i_rdata,
    output logic            i_done,
    input  logic            d_req,
    input  logic [DW/8-1:0] d_wen,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic [DW-1:0]   d_rdata,
    output logic            d_done,
    output logic            ram_en,
    output logic [DW/8-1:0] ram_wen,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_wdata,
    input  logic [DW-1:0]   ram_rdata,
    output logic [1:0]      grant_o
);

    localparam int BW = DW / 8;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    owner_t owner_q;
    owner_t owner_d;
    logic   gnt_i;
    logic   gnt_d;
    logic   both_req;
    logic   inst_wins_tie;
    logic   d_wr_q;

    // A port completing with req still high is a fresh back-to-back request, so req alone decides eligibility.
    assign both_req = i_req && d_req;

`ifdef ARB_RR_EN
    logic last_grant_q;

    // last_grant_q: 0 = inst was granted last, 1 = data was granted last.
    assign inst_wins_tie = last_grant_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant_q <= 1'b0;
        end else if (gnt_d) begin
            last_grant_q <= 1'b1;
        end else if (gnt_i) begin
            last_grant_q <= 1'b0;
        end
    end
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q;

    assign inst_wins_tie = (starve_cnt_q == LIMIT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt_q <= 4'd0;
        end else if (gnt_i) begin
            starve_cnt_q <= 4'd0;
        end else if (both_req && gnt_d && (starve_cnt_q != LIMIT)) begin
            starve_cnt_q <= starve_cnt_q + 4'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q <= OWN_IDLE;
            d_wr_q  <= 1'b0;
        end else begin
            owner_q <= owner_d;
            d_wr_q  <= gnt_d && (d_wen != '0);
        end
    end

    // Grants are masked while reset is held so the RAM sees no enable until release.
    always_comb begin
        gnt_i   = 1'b0;
        gnt_d   = 1'b0;
        owner_d = OWN_IDLE;
        if (resetn) begin
            if (both_req) begin
                if (inst_wins_tie) begin
                    gnt_i = 1'b1;
                end else begin
                    gnt_d = 1'b1;
                end
            end else if (i_req) begin
                gnt_i = 1'b1;
            end else if (d_req) begin
                gnt_d = 1'b1;
            end
        end
        if (gnt_i) begin
            owner_d = OWN_INST;
        end else if (gnt_d) begin
            owner_d = OWN_DATA;
        end
    end

    always_comb begin
        ram_en    = gnt_i || gnt_d;
        ram_wen   = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        grant_o   = {gnt_d, gnt_i};
        if (gnt_d) begin
            ram_wen   = d_wen;
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
        end else if (gnt_i) begin
            ram_addr  = i_addr;
        end
        i_done  = (owner_q == OWN_INST);
        d_done  = (owner_q == OWN_DATA);
        i_rdata = i_done ? ram_rdata : '0;
        // A completing write returns zero; the RAM output that cycle is not meaningful read data.
        d_rdata = (d_done && !d_wr_q) ? ram_rdata : '0;
    end

`ifndef SYNTHESIS
    logic [BW-1:0] unused_bw;
    assign unused_bw = '0;

    // A waiting requester must hold req and its request fields until it is granted.
    a_i_stable: assert property (@(posedge clk) disable iff (!resetn)
        (i_req && !gnt_i) |=> (i_req && $stable(i_addr)));
    a_d_stable: assert property (@(posedge clk) disable iff (!resetn)
        (d_req && !gnt_d) |=> (d_req && $stable(d_addr) && $stable(d_wen) && $stable(d_wdata)));
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter with a behavioural 1-cycle SRAM
module tb_sram_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_req = 1'b0;
    logic [3:0]  d_wen = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic [1:0]  grant_o;

    logic [31:0] cyc = '0;
    logic [31:0] mem [0:255];
    exp_t        iq[$];
    exp_t        dq[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        mon_en = 1'b0;

    sram_arbiter dut (
        .clk       (clk),
        .resetn    (resetn),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_wen     (d_wen),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .ram_en    (ram_en),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .grant_o   (grant_o)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wen[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            ram_rdata <= mem[ram_addr[9:2]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_i(input logic [31:0] data);
        iq.push_back('{data: data, cyc: cyc + 32'd1});
    endtask

    task automatic push_d(input logic [31:0] data);
        dq.push_back('{data: data, cyc: cyc + 32'd1});
    endtask

    // Monitor: every done pulse must match the oldest expected response of its port, in data and cycle.
    always @(negedge clk) begin
        if (mon_en && i_done) begin
            if (iq.size() == 0) begin
                check("i_done_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = iq.pop_front();
                check("i_rdata", i_rdata, e.data);
                check("i_done_cycle", cyc, e.cyc);
            end
        end
        if (mon_en && d_done) begin
            if (dq.size() == 0) begin
                check("d_done_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = dq.pop_front();
                check("d_rdata", d_rdata, e.data);
                check("d_done_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        // exp_inst[k] = 1 when the inst port must win contended cycle k.
`ifdef ARB_RR_EN
        // The previous grant (the data read) was DATA, so alternation starts with INST.
        int exp_inst[10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
`else
        int exp_inst[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif

        for (int k = 0; k < 256; k++) mem[k] = 32'hA000_0000 + k;
        mem[0]  = 32'h2408_000A;
        mem[16] = 32'h1122_3344;

        // Reset state, including a request held during reset.
        repeat (3) @(posedge clk);
        i_req = 1'b1;
        @(negedge clk);
        check("rst_ram_en", {31'd0, ram_en}, 32'd0);
        check("rst_grant", {30'd0, grant_o}, 32'd0);
        check("rst_done", {30'd0, i_done, d_done}, 32'd0);
        check("rst_rdata", i_rdata | d_rdata, 32'd0);
        check("rst_ram_bus", {28'd0, ram_wen} | ram_addr | ram_wdata, 32'd0);
        i_req = 1'b0;
        mon_en = 1'b1;
        #2 resetn = 1'b1;

        // Single uncontended fetch.
        tick();
        i_req = 1'b1; i_addr = 32'h0;
        push_i(32'h2408_000A);
        @(negedge clk);
        check("fetch_grant", {30'd0, grant_o}, 32'd1);
        check("fetch_ram_en", {31'd0, ram_en}, 32'd1);
        check("fetch_ram_wen", {28'd0, ram_wen}, 32'd0);
        tick();
        i_req = 1'b0;

        // Partial write then back-to-back read of the same word.
        tick();
        d_req = 1'b1; d_wen = 4'b0011; d_addr = 32'h40; d_wdata = 32'hAABB_CCDD;
        push_d(32'h0);
        @(negedge clk);
        check("wr_grant", {30'd0, grant_o}, 32'd2);
        check("wr_ram_wen", {28'd0, ram_wen}, 32'h3);
        check("wr_ram_addr", ram_addr, 32'h40);
        check("wr_ram_wdata", ram_wdata, 32'hAABB_CCDD);
        tick();
        d_wen = 4'b0000; d_wdata = 32'h0;
        push_d(32'h1122_CCDD);
        @(negedge clk);
        check("rd_ram_wen", {28'd0, ram_wen}, 32'd0);
        tick();
        d_req = 1'b0;

        // Both ports held: grant pattern across two starvation windows.
        tick();
        i_req = 1'b1; i_addr = 32'h4;
        d_req = 1'b1; d_addr = 32'h8;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            if (exp_inst[k] == 1) push_i(32'hA000_0001);
            else push_d(32'hA000_0002);
            @(negedge clk);
            check($sformatf("contend_grant_%0d", k), {30'd0, grant_o},
                  (exp_inst[k] == 1) ? 32'd1 : 32'd2);
        end
        tick();
        // Let whichever port lost the last contended cycle complete alone.
        if (exp_inst[9] == 1) begin
            i_req = 1'b0;
            push_d(32'hA000_0002);
        end else begin
            d_req = 1'b0;
            push_i(32'hA000_0001);
        end
        tick();
        i_req = 1'b0; d_req = 1'b0;

        // Back-to-back fetches with a new address in each done cycle.
        tick();
        i_req = 1'b1; i_addr = 32'h0; push_i(32'h2408_000A);
        tick();
        i_addr = 32'h4; push_i(32'hA000_0001);
        tick();
        i_addr = 32'h8; push_i(32'hA000_0002);
        tick();
        i_req = 1'b0;

        // Asynchronous reset while the data port owns the RAM: no done may follow.
        tick();
        d_req = 1'b1; d_addr = 32'h40; d_wen = 4'b0000;
        tick();
        resetn = 1'b0;
        @(negedge clk);
        check("mid_rst_ram_en", {31'd0, ram_en}, 32'd0);
        check("mid_rst_d_done", {31'd0, d_done}, 32'd0);
        check("mid_rst_d_rdata", d_rdata, 32'd0);
        tick();
        @(negedge clk);
        check("mid_rst_ram_en2", {31'd0, ram_en}, 32'd0);
        d_req = 1'b0;
        #2 resetn = 1'b1;
        tick();
        i_req = 1'b1; i_addr = 32'h8;
        push_i(32'hA000_0002);
        tick();
        i_req = 1'b0;

        // Idle: outputs stay quiet even though the RAM still presents its last read.
        tick();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_ram_en", {31'd0, ram_en}, 32'd0);
            check("idle_done", {30'd0, i_done, d_done}, 32'd0);
            check("idle_i_rdata", i_rdata, 32'd0);
            check("idle_d_rdata", d_rdata, 32'd0);
        end

        repeat (2) tick();
        check("iq_drained", iq.size(), 32'd0);
        check("dq_drained", dq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one single-port synchronous SRAM (1-cycle read latency) between the CPU instruction port and data port.
- Lets the SoC top use a single unified RAM instead of separate inst/data RAMs.
- Each port uses a req/done handshake. The arbiter sequences RAM accesses one per cycle, steers read data back, and enforces fairness so fetch cannot starve.

Parameters:
- AW, 32, address width of ports and RAM.
- DW, 32, data width. Must be a multiple of 8; byte enables are DW/8 bits.
- STARVE_LIMIT, 4, consecutive contended cycles the inst port may lose before it is forced a grant. Range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- i_req  in  1  inst read request; held until i_done.
- i_addr  in  AW  inst byte address; stable while i_req=1.
- i_rdata  out  DW  inst read data; valid only when i_done=1, else 0.
- i_done  out  1  one-cycle pulse: inst access complete.
- d_req  in  1  data request; held until d_done.
- d_wen  in  DW/8  byte write enables; 0 means read.
- d_addr  in  AW  data byte address.
- d_wdata  in  DW  write data.
- d_rdata  out  DW  data read data; valid only when d_done=1, else 0.
- d_done  out  1  one-cycle pulse: data access complete (reads and writes).
- ram_en  out  1  RAM enable.
- ram_wen  out  DW/8  RAM byte write enables.
- ram_addr  out  AW  RAM address. Byte address passed unchanged; word indexing is done by the RAM.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data, valid the cycle after ram_en.
- grant_o  out  2  debug: {data,inst} one-hot grant of the current cycle.

Behaviour:
- State register owner ∈ {IDLE, INST, DATA}: the port whose access was issued last cycle.
- Reset state: owner=IDLE, starve_cnt=0, all done=0, all rdata=0, ram_en=0, ram_wen=0, grant_o=0.
- Reset is asynchronous and active-low and may assert mid-operation. It drops any in-flight access; no done is produced for it.

Eligibility and grant:
- A port is eligible in cycle T if its req=1 and it is not currently completing (owner≠port), or if it is completing and req is still high. A req held high in the done cycle is a new back-to-back request; the requester must present the next address that cycle or drop req.
- Grant is combinational in cycle T:
  - Only one port eligible: that port wins.
  - Both eligible: DATA wins, unless starve_cnt == STARVE_LIMIT, in which case INST wins.
- On a grant, drive ram_en=1 and mux ram_addr/ram_wen/ram_wdata from the winner. For an inst grant, ram_wen=0 and ram_wdata=0. With no grant, ram_en=0 and the other RAM outputs are 0.
- At posedge, owner := winner, or IDLE if there is no grant.

Completion:
- In cycle T+1, x_done=1 for the owner and x_rdata = ram_rdata. The other port has done=0 and rdata=0.
- Latency: req to done is exactly 1 cycle when the port is uncontended.
- Throughput: one access per cycle sustained, alternating or back-to-back.

Writes:
- Committed by the RAM at the grant edge. d_done still pulses at T+1 and d_rdata=0.
- Partial byte enables pass through unmodified.

Starvation counter (starve_cnt):
- Increments when both are eligible and DATA wins; saturates at STARVE_LIMIT.
- Clears on any inst grant.
- Holds otherwise.

Prohibited input:
- Changing addr/wen/wdata while req=1 before done is a protocol violation. Simulation asserts flag it; RTL behaviour is undefined.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: on contention, grant alternates via a last_grant flip-flop (reset value INST, so DATA wins the first contention); starve_cnt logic is removed.
- Undefined: fixed data priority with the STARVE_LIMIT guard as above.
- Handshake timing is identical in both builds.

Test Plan:
- Reset, then i_req=1 with i_addr=0x00; RAM word0=0x2408000A → next cycle i_done=1, i_rdata=0x2408000A, grant_o=01 in the request cycle.
- d_req write d_wen=4'b0011, d_addr=0x40, d_wdata=0xAABBCCDD over word 0x11223344, then a read of 0x40 → d_done on both, read returns 0x1122CCDD.
- i_req and d_req both held continuously, STARVE_LIMIT=4 → grant pattern D,D,D,D,I repeating; starve_cnt never exceeds 4. With ARB_RR_EN: D,I,D,I.
- i_req held with a new address in each done cycle, no d_req → i_done high every cycle; addresses 0x0,0x4,0x8 return their 3 words in order.
- resetn dropped asynchronously mid-cycle while owner=DATA → d_done stays 0, ram_en=0 immediately, owner=IDLE. First request after release completes in 1 cycle.
- Idle (no req) for 10 cycles → ram_en=0, both done=0, both rdata=0 every cycle.
